// File: rtl/toy_run_ctrl_if.sv
// toy_run_ctrl_if: control, breakpoint and status bundle between toy_run_ctrl and the board/bench.
// pc_hist exists only when TOY_RUN_CTRL_PCLOG_EN is defined.
interface toy_run_ctrl_if #(parameter int PC_W = 12, parameter int CNT_W = 32);
  logic start;
  logic step_mode;
  logic step;
  logic halt_req;
  logic bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] pc_in;
  logic halted_in;
  logic cpu_reset;
  logic cpu_en;
  logic [2:0] state;
  logic [CNT_W-1:0] cycle_cnt;
  logic bp_hit;
  logic done;
`ifdef TOY_RUN_CTRL_PCLOG_EN
  logic [4*PC_W-1:0] pc_hist;
`endif
  modport master (
    output start, step_mode, step, halt_req, bp_en, bp_addr, pc_in, halted_in,
    input cpu_reset, cpu_en, state, cycle_cnt, bp_hit, done
`ifdef TOY_RUN_CTRL_PCLOG_EN
    , input pc_hist
`endif
  );
  modport slave (
    input start, step_mode, step, halt_req, bp_en, bp_addr, pc_in, halted_in,
    output cpu_reset, cpu_en, state, cycle_cnt, bp_hit, done
`ifdef TOY_RUN_CTRL_PCLOG_EN
    , output pc_hist
`endif
  );
endinterface

// File: rtl/toy_run_ctrl.sv
// toy_run_ctrl: reset sequencing, run/step/breakpoint/halt control and cycle counting for the Toy CPU.
// Defining TOY_RUN_CTRL_PCLOG_EN adds a 4-deep log of executed PCs on pc_hist.
module toy_run_ctrl #(
  parameter int PC_W       = 12,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input logic clk,
  input logic reset,
  toy_run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_PAUSE = 3'd4,
    S_HALT  = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bp_skip_q, bp_skip_d;
  logic bp_hit_q, bp_hit_d;
  logic cpu_reset_q, done_q;
  logic bp_stop, launch, en;
  // bp_skip lets a resume from a breakpoint execute the instruction it stopped on
  assign bp_stop = bus.bp_en && (bus.pc_in == bus.bp_addr) && !bp_skip_q;
  assign en = (state_q == S_STEP) || (state_q == S_RUN && !bp_stop);
  always_comb begin
    state_d = state_q;
    rcnt_d = rcnt_q;
    bp_skip_d = 1'b0;
    bp_hit_d = 1'b0;
    launch = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: if (bus.start) begin
        state_d = S_RESET;
        rcnt_d = 8'(RST_CYCLES - 1);
        launch = 1'b1;
      end
      S_RESET: if (rcnt_q == 8'd0) state_d = bus.step_mode ? S_PAUSE : S_RUN;
               else rcnt_d = rcnt_q - 8'd1;
      S_RUN: if (bus.halted_in) state_d = S_HALT;
             else if (bus.halt_req) state_d = S_PAUSE;
             else if (bp_stop) begin
               state_d = S_PAUSE;
               bp_hit_d = 1'b1;
             end
      S_STEP: state_d = bus.halted_in ? S_HALT : S_PAUSE;
      S_PAUSE: if (bus.step) state_d = S_STEP;
               else if (bus.start) begin
                 state_d = S_RUN;
                 bp_skip_d = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
    cnt_d = launch ? '0 : (en && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rcnt_q <= '0;
      cnt_q <= '0;
      bp_skip_q <= 1'b0;
      bp_hit_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      cnt_q <= cnt_d;
      bp_skip_q <= bp_skip_d;
      bp_hit_q <= bp_hit_d;
      cpu_reset_q <= (state_d == S_IDLE) || (state_d == S_RESET);
      done_q <= (state_d == S_HALT);
    end
  end
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.cpu_en = en;
  assign bus.state = state_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.bp_hit = bp_hit_q;
  assign bus.done = done_q;
`ifdef TOY_RUN_CTRL_PCLOG_EN
  logic [4*PC_W-1:0] hist_q, hist_d;
  always_comb hist_d = launch ? '0 : en ? {hist_q[3*PC_W-1:0], bus.pc_in} : hist_q;
  always_ff @(posedge clk) begin
    if (!reset) hist_q <= '0;
    else hist_q <= hist_d;
  end
  assign bus.pc_hist = hist_q;
`endif
endmodule

// File: tb/tb_toy_run_ctrl.sv
// tb_toy_run_ctrl: directed stimulus with per-cycle expected outputs queued to a scoreboard monitor.
module tb_toy_run_ctrl;
  localparam int PC_W = 12;
  localparam logic [2:0] I = 3'd0, R = 3'd1, U = 3'd2, S = 3'd3, P = 3'd4, H = 3'd5;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  toy_run_ctrl_if #(.PC_W(PC_W), .CNT_W(32)) bus ();
  toy_run_ctrl_if #(.PC_W(PC_W), .CNT_W(4)) bus4 ();
  assign bus4.start = bus.start;
  assign bus4.step_mode = bus.step_mode;
  assign bus4.step = bus.step;
  assign bus4.halt_req = bus.halt_req;
  assign bus4.bp_en = bus.bp_en;
  assign bus4.bp_addr = bus.bp_addr;
  assign bus4.pc_in = bus.pc_in;
  assign bus4.halted_in = bus.halted_in;

  toy_run_ctrl #(.PC_W(PC_W), .RST_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  toy_run_ctrl #(.PC_W(PC_W), .RST_CYCLES(2), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  typedef struct {
    string n;
    logic [2:0] st;
    logic cr;
    logic en;
    int cnt;
    logic hit;
    logic dn;
    int c4;
    logic [4*PC_W-1:0] h;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string n, input string f, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!$isunknown(e.st)) chk(e.n, "state", 64'(bus.state), 64'(e.st));
      if (!$isunknown(e.cr)) chk(e.n, "cpu_reset", 64'(bus.cpu_reset), 64'(e.cr));
      if (!$isunknown(e.en)) chk(e.n, "cpu_en", 64'(bus.cpu_en), 64'(e.en));
      if (e.cnt >= 0) chk(e.n, "cycle_cnt", 64'(bus.cycle_cnt), 64'(e.cnt));
      if (!$isunknown(e.hit)) chk(e.n, "bp_hit", 64'(bus.bp_hit), 64'(e.hit));
      if (!$isunknown(e.dn)) chk(e.n, "done", 64'(bus.done), 64'(e.dn));
      if (e.c4 >= 0) chk(e.n, "cycle_cnt4", 64'(bus4.cycle_cnt), 64'(e.c4));
`ifdef TOY_RUN_CTRL_PCLOG_EN
      if (!$isunknown(e.h)) chk(e.n, "pc_hist", 64'(bus.pc_hist), 64'(e.h));
`endif
    end
  end

  // queue the expected outputs for the current cycle, then advance one clock
  task automatic cy(input string n, input logic [2:0] st, input logic cr, input logic en, input int cnt,
                    input logic hit, input logic dn, input int c4 = -1, input logic [4*PC_W-1:0] h = 'x);
    exp_t e;
    e.n = n; e.st = st; e.cr = cr; e.en = en; e.cnt = cnt; e.hit = hit; e.dn = dn; e.c4 = c4; e.h = h;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.halt_req = 0;
    bus.bp_en = 0; bus.bp_addr = '0; bus.pc_in = '0; bus.halted_in = 0;
    @(posedge clk);
    #1;
    cy("reset", I, 1, 0, 0, 0, 0, 0, '0);
    reset = 1'b1; bus.start = 1;
    cy("idle_start", I, 1, 0, 0, 0, 0);
    bus.start = 0;
    cy("rst_c1", R, 1, 0, 0, 0, 0);
    cy("rst_c2", R, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cy("run", U, 0, 1, k, 0, 0);
    bus.bp_en = 1; bus.bp_addr = 12'h010;
    for (int k = 0; k < 4; k++) begin
      bus.pc_in = 12'(12'h00C + k);
      cy("bp_ramp", U, 0, 1, 5 + k, 0, 0);
    end
    bus.pc_in = 12'h010;
    cy("bp_stop", U, 0, 0, 9, 0, 0);
    cy("bp_hit", P, 0, 0, 9, 1, 0);
    cy("bp_once", P, 0, 0, 9, 0, 0);
    bus.start = 1;
    cy("resume_cmd", P, 0, 0, 9, 0, 0);
    bus.start = 0;
    cy("resume_exec", U, 0, 1, 9, 0, 0);
    bus.pc_in = 12'h011;
    cy("no_2nd_hit", U, 0, 1, 10, 0, 0);
    bus.bp_addr = 12'h011; bus.halted_in = 1; bus.halt_req = 1;
    cy("halt_prio", U, 0, 0, 11, 0, 0);
    bus.halted_in = 0; bus.halt_req = 0; bus.pc_in = 12'h020;
    cy("halt", H, 0, 0, 11, 0, 1);
    cy("halt_frozen", H, 0, 0, 11, 0, 1);
    bus.start = 1;
    cy("relaunch_cmd", H, 0, 0, 11, 0, 1);
    bus.start = 0; bus.bp_en = 0; bus.step_mode = 1;
    cy("relaunch_r1", R, 1, 0, 0, 0, 0, -1, '0);
    cy("relaunch_r2", R, 1, 0, 0, 0, 0);
    bus.step = 1;
    cy("step_p", P, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      bus.pc_in = 12'(k + 1);
      cy("step_s", S, 0, 1, k, 0, 0);
      if (k < 2) cy("step_p", P, 0, 0, k + 1, 0, 0);
    end
    bus.step = 0;
    cy("step_done", P, 0, 0, 3, 0, 0);
    bus.start = 1; bus.pc_in = 12'h004;
    cy("resume2", P, 0, 0, 3, 0, 0);
    bus.start = 0;
    cy("run_pc4", U, 0, 1, 3, 0, 0);
    bus.pc_in = 12'h005; bus.halt_req = 1;
    cy("halt_req", U, 0, 1, 4, 0, 0);
    bus.halt_req = 0;
    cy("hreq_pause", P, 0, 0, 5, 0, 0, 5, {12'h002, 12'h003, 12'h004, 12'h005});
    bus.start = 1; bus.pc_in = '0;
    cy("resume3", P, 0, 0, 5, 0, 0);
    bus.start = 0;
    for (int k = 0; k < 20; k++) cy("sat_run", U, 0, 1, 5 + k, 0, 0, (5 + k > 15) ? 15 : 5 + k);
    reset = 1'b0;
    cy("pre_midrst", U, 0, 1, 25, 0, 0, 15);
    reset = 1'b1;
    cy("midrst", I, 1, 0, 0, 0, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
